// File: rtl/conv_window_gen.sv
// -----------------------------------------------------------------------------
// conv_window_gen
//
// Sliding-window generator for the convolution datapath. Consumes a
// raster-order pixel stream and presents, for every accepted pixel, the K x K
// neighbourhood whose bottom-right (newest) element is that pixel.
//
// Optional feature macro: WINDOW_STRIDE2_EN
//   undefined : stride 1, every fully-inside window is flagged valid
//   defined   : stride 2, only windows whose top-left offset is even in both
//               dimensions are flagged valid
//
// Ports
//   clk         sole clock, rising edge
//   rst_n       asynchronous, active-low reset
//   in_valid    in_data carries a pixel this cycle
//   in_sof      with in_valid: this pixel is (row 0, col 0)
//   in_data     pixel, raster order
//   out_valid   out_window holds a complete in-frame window
//   out_window  flattened window, element (r,c) at [(r*K+c)*DATA_WIDTH +: DATA_WIDTH]
//   out_row     row of the newest pixel in the window
//   out_col     column of the newest pixel in the window
// -----------------------------------------------------------------------------
module conv_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int K          = 3,
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int CW         = $clog2(IMG_WIDTH),
    parameter int RW         = $clog2(IMG_HEIGHT)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    input  logic                      in_sof,
    input  logic [DATA_WIDTH-1:0]     in_data,
    output logic                      out_valid,
    output logic [K*K*DATA_WIDTH-1:0] out_window,
    output logic [RW-1:0]             out_row,
    output logic [CW-1:0]             out_col
);

    typedef logic [DATA_WIDTH-1:0] pix_t;

`ifdef WINDOW_STRIDE2_EN
    // Parity of K-1; bit 0 of (pos - (K-1)) is pos[0] ^ this.
    localparam logic K1_ODD = 1'((K - 1) % 2);
`endif

    // Position of the next pixel to be accepted.
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    // Position of the pixel offered this cycle (in_sof overrides the counters).
    logic [RW-1:0] pos_row;
    logic [CW-1:0] pos_col;
    logic          win_ok;

    logic          out_valid_q;
    logic [RW-1:0] out_row_q;
    logic [CW-1:0] out_col_q;

    // win_q[r][c]: r=0 oldest line, c=0 leftmost column.
    pix_t win_q [K][K];
    // lb_q[i][col]: pixel from i+1 lines earlier at that column.
    pix_t lb_q [K-1][IMG_WIDTH];
    // Column entering the window: col_vec[K-1] is the new pixel.
    pix_t col_vec [K];

    // NOTE: every output of a combinational block is given a value on every
    // path (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        pos_row = in_sof ? '0 : row_q;
        pos_col = in_sof ? '0 : col_q;

        row_d = row_q;
        col_d = col_q;
        if (in_valid) begin
            if (pos_col == CW'(IMG_WIDTH - 1)) begin
                col_d = '0;
                row_d = (pos_row == RW'(IMG_HEIGHT - 1)) ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end
        end

        // Windows touching the top rows or wrapping across a line edge are
        // never flagged; that also hides stale line-buffer data after in_sof.
        win_ok = (pos_row >= RW'(K - 1)) && (pos_col >= CW'(K - 1));
`ifdef WINDOW_STRIDE2_EN
        win_ok = win_ok && !(pos_row[0] ^ K1_ODD) && !(pos_col[0] ^ K1_ODD);
`endif

        col_vec[K-1] = in_data;
        for (int i = 0; i < K - 1; i++) begin
            col_vec[K-2-i] = lb_q[i][pos_col];
        end
    end

    // NOTE: the line buffers are plain storage with no reset; the validity
    // gate guarantees their power-up contents never reach a valid window.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            lb_q[0][pos_col] <= in_data;
            for (int i = 1; i < K - 1; i++) begin
                lb_q[i][pos_col] <= lb_q[i-1][pos_col];
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q       <= '0;
            col_q       <= '0;
            out_valid_q <= 1'b0;
            out_row_q   <= '0;
            out_col_q   <= '0;
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    win_q[r][c] <= '0;
                end
            end
        end else begin
            row_q       <= row_d;
            col_q       <= col_d;
            out_valid_q <= in_valid && win_ok;
            if (in_valid) begin
                out_row_q <= pos_row;
                out_col_q <= pos_col;
                // Shift the window left by one column and load the new column.
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_q[r][c] <= win_q[r][c+1];
                    end
                    win_q[r][K-1] <= col_vec[r];
                end
            end
        end
    end

    always_comb begin
        out_window = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                out_window[(r*K+c)*DATA_WIDTH +: DATA_WIDTH] = win_q[r][c];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen
//
// Directed bench for conv_window_gen at default parameters. Pixel value is
// row*8+col; the expected window for a pixel at (r,c) is built from that rule.
// -----------------------------------------------------------------------------
module tb_conv_window_gen;

    localparam int DW   = 8;
    localparam int K    = 3;
    localparam int W    = 8;
    localparam int H    = 8;
    localparam int WINW = K * K * DW;

`ifdef WINDOW_STRIDE2_EN
    localparam int EXP_WIN = ((W - K) / 2 + 1) * ((H - K) / 2 + 1);
`else
    localparam int EXP_WIN = (W - K + 1) * (H - K + 1);
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            in_sof;
    logic [DW-1:0]   in_data;
    logic            out_valid;
    logic [WINW-1:0] out_window;
    logic [2:0]      out_row;
    logic [2:0]      out_col;

    int n_tests = 0;
    int n_fail  = 0;
    int last_r  = 0;
    int last_c  = 0;
    bit last_ok = 1'b0;

    conv_window_gen dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_window(out_window),
        .out_row   (out_row),
        .out_col   (out_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_valid(input int r, input int c);
        bit v;
        v = (r >= K - 1) && (c >= K - 1);
`ifdef WINDOW_STRIDE2_EN
        v = v && ((r - (K - 1)) % 2 == 0) && ((c - (K - 1)) % 2 == 0);
`endif
        return v;
    endfunction

    function automatic logic [WINW-1:0] exp_win(input int r, input int c);
        logic [WINW-1:0] w;
        int v;
        w = '0;
        for (int rr = 0; rr < K; rr++) begin
            for (int cc = 0; cc < K; cc++) begin
                v = (r - (K - 1) + rr) * W + (c - (K - 1) + cc);
                w[(rr*K+cc)*DW +: DW] = DW'(v);
            end
        end
        return w;
    endfunction

    // Offer one pixel at (r,c) and check the registered result after the edge.
    task automatic pix(input int r, input int c, input bit sof,
                       inout int n_win, inout int first_idx);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = DW'(r * W + c);
        @(posedge clk);
        #1;
        check($sformatf("row(%0d,%0d)", r, c), out_row, r);
        check($sformatf("col(%0d,%0d)", r, c), out_col, c);
        check($sformatf("valid(%0d,%0d)", r, c), out_valid, exp_valid(r, c));
        if (exp_valid(r, c)) begin
            check($sformatf("window(%0d,%0d)", r, c), out_window, exp_win(r, c));
        end
        if (out_valid === 1'b1) begin
            if (first_idx < 0) first_idx = r * W + c;
            n_win++;
        end
        last_r  = r;
        last_c  = c;
        last_ok = (r >= K - 1) && (c >= K - 1);
    endtask

    // Idle cycle: out_valid must drop, everything else must hold.
    task automatic idle(input bit sof_noise);
        in_valid = 1'b0;
        in_sof   = sof_noise;
        in_data  = DW'($urandom);
        @(posedge clk);
        #1;
        check("idle_valid", out_valid, 1'b0);
        check("idle_row", out_row, last_r);
        check("idle_col", out_col, last_c);
        if (last_ok) begin
            check("idle_window", out_window, exp_win(last_r, last_c));
        end
    endtask

    task automatic frame(input bit sof_first, input bit gaps,
                         output int n_win, output int first_idx);
        n_win     = 0;
        first_idx = -1;
        for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
                if (gaps && $urandom_range(0, 1) == 1) idle($urandom_range(0, 1) == 1);
                pix(r, c, sof_first && r == 0 && c == 0, n_win, first_idx);
            end
        end
    endtask

    initial begin
        int nw1, fi1, nw2, fi2, nw, fi;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;

        // Reset state
        #12;
        check("rst_valid", out_valid, 1'b0);
        check("rst_window", out_window, '0);
        check("rst_row", out_row, 0);
        check("rst_col", out_col, 0);
        rst_n = 1'b1;

        // Full frame then a back-to-back frame, no gaps
        frame(1'b1, 1'b0, nw1, fi1);
        check("f1_count", nw1, EXP_WIN);
        check("f1_first", fi1, 18);
        frame(1'b1, 1'b0, nw2, fi2);
        check("f2_count", nw2, EXP_WIN);
        check("f2_first", fi2, 18);
        check("f12_total", nw1 + nw2, 2 * EXP_WIN);

        // Partial frame abandoned mid-line, then in_sof restarts with gaps
        nw = 0;
        fi = -1;
        for (int c = 0; c < W; c++) pix(0, c, 1'b0, nw, fi);
        for (int c = 0; c < 3; c++) pix(1, c, 1'b0, nw, fi);
        frame(1'b1, 1'b1, nw, fi);
        check("gap_count", nw, EXP_WIN);
        check("gap_first", fi, 18);

        // Reset pulse after pixel 30, then restart without in_sof
        nw = 0;
        fi = -1;
        for (int p = 0; p <= 30; p++) pix(p / W, p % W, p == 0, nw, fi);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        check("arst_valid", out_valid, 1'b0);
        check("arst_window", out_window, '0);
        check("arst_row", out_row, 0);
        check("arst_col", out_col, 0);
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        last_r  = 0;
        last_c  = 0;
        last_ok = 1'b0;
        idle(1'b0);
        frame(1'b0, 1'b0, nw, fi);
        check("rst_frame_count", nw, EXP_WIN);
        check("rst_frame_first", fi, 18);

        in_valid = 1'b0;
        in_sof   = 1'b0;
        @(posedge clk);
        #1;
        check("final_valid", out_valid, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
